// File: rtl/store_buffer_lsu.sv
// store_buffer_lsu: in-order store buffer and load sequencer in front of memory_data.
// Stores are queued and drained one per cycle; loads wait until every older store has
// been written. All memory_data inputs come straight from flops.
module store_buffer_lsu #(
  parameter int SB_DEPTH = 4,
  parameter int ADDRW    = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_sel,
  input  logic [ADDRW-1:0]          req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      ld_valid,
  output logic [31:0]               ld_data,
  output logic                      mem_write,
  output logic                      mem_read,
  output logic [ADDRW-1:0]          mem_addr,
  output logic [2:0]                mem_sel,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_empty
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDRW + 3 + 32;

  typedef enum logic {ST_IDLE, ST_LOAD} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mem_write_q, mem_write_d;
  logic             mem_read_q, mem_read_d;
  logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]       mem_sel_q, mem_sel_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             ld_valid_q, ld_valid_d;
  logic [31:0]      ld_data_q, ld_data_d;

  // Entry layout: {addr, sel, wdata}
  logic [EW-1:0]    fifo_mem [SB_DEPTH];
  logic [EW-1:0]    head;

  logic full, empty, store_sel_ok, load_sel_ok;
  logic store_acc, load_acc, push, pop;

  assign full  = (count_q == CW'(SB_DEPTH));
  assign empty = (count_q == '0);
  assign head  = fifo_mem[rd_ptr_q];

  // Only B/H/W are meaningful for a store; anything else is swallowed without a push.
  assign store_sel_ok = (req_sel == 3'b000) || (req_sel == 3'b001) || (req_sel == 3'b010);
  // Reserved load encodings still run through the sequence but return zero.
  assign load_sel_ok  = !((mem_sel_q == 3'b011) || (mem_sel_q == 3'b110) || (mem_sel_q == 3'b111));

  // Stores need a free slot; loads need an empty buffer and an idle sequencer.
  // Held low while in reset so every output reads zero.
  always_comb begin
    if (req_we) req_ready = rst_n & ~full;
    else        req_ready = rst_n & (state_q == ST_IDLE) & empty;
  end

  assign store_acc = req_valid & req_ready & req_we;
  assign load_acc  = req_valid & req_ready & ~req_we;
  assign push      = store_acc & store_sel_ok;
  assign pop       = (state_q == ST_IDLE) & ~empty;

  // Next-state: drain the head, launch loads, and capture load results.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_sel_d   = mem_sel_q;
    mem_wdata_d = mem_wdata_q;
    ld_valid_d  = 1'b0;
    ld_data_d   = ld_data_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      mem_addr_d  = head[EW-1 -: ADDRW];
      mem_sel_d   = head[34:32];
      mem_wdata_d = head[31:0];
      mem_write_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A load is only accepted with the buffer empty, so it never collides with a pop.
    if (load_acc) begin
      mem_addr_d = req_addr;
      mem_sel_d  = req_sel;
      mem_read_d = 1'b1;
      state_d    = ST_LOAD;
    end

    if (state_q == ST_LOAD) begin
      ld_data_d  = load_sel_ok ? mem_rdata : 32'd0;
      ld_valid_d = 1'b1;
      state_d    = ST_IDLE;
    end
  end

  // Control state and memory-port registers; reset drops queued stores and pending loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_sel_q   <= '0;
      mem_wdata_q <= '0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      mem_sel_q   <= mem_sel_d;
      mem_wdata_q <= mem_wdata_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {req_addr, req_sel, req_wdata};
  end

  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;
  assign mem_addr  = mem_addr_q;
  assign mem_sel   = mem_sel_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign sb_count  = count_q;
  assign sb_empty  = empty;

endmodule

// File: tb/tb_store_buffer_lsu.sv
// Testbench for store_buffer_lsu: behavioural memory_data model, directed vector table,
// hand-written corner sequences and a randomized run against a byte-level golden memory.
module tb_store_buffer_lsu;

  localparam int ADDRW = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready, req_we;
  logic [2:0]       req_sel;
  logic [ADDRW-1:0] req_addr;
  logic [31:0]      req_wdata;
  logic             ld_valid;
  logic [31:0]      ld_data;
  logic             mem_write, mem_read;
  logic [ADDRW-1:0] mem_addr;
  logic [2:0]       mem_sel;
  logic [31:0]      mem_wdata, mem_rdata;
  logic [2:0]       sb_count;
  logic             sb_empty;

  store_buffer_lsu #(.SB_DEPTH(4), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct { logic [11:0] a; logic [2:0] s; logic [31:0] d; } wr_t;
  typedef struct { int c; logic [31:0] d; } ld_t;
  typedef struct {
    logic [2:0] st_sel; logic [11:0] st_addr; logic [31:0] st_data;
    logic [2:0] ld_sel; logic [11:0] ld_addr; logic [31:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int writes_seen = 0;

  logic [7:0] mem  [4096];   // memory_data contents, written only by the DUT port
  logic [7:0] gmem [4096];   // golden memory, updated when a store is accepted
  wr_t wr_log[$];
  ld_t ld_log[$];
  logic [31:0] mem_raw;

  function automatic logic [31:0] ext(input logic [2:0] sel, input logic [31:0] raw);
    case (sel)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b010:  return raw;
      3'b100:  return {24'd0, raw[7:0]};
      3'b101:  return {16'd0, raw[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] sel);
    if (sel == 3'b000) return 1;
    if (sel == 3'b001) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] graw(input logic [11:0] a);
    return {gmem[a + 12'd3], gmem[a + 12'd2], gmem[a + 12'd1], gmem[a]};
  endfunction

  // memory_data read port: combinational, extension by sel; reserved sels return raw bytes
  always_comb begin
    mem_raw = {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2], mem[mem_addr + 12'd1], mem[mem_addr]};
    if ((mem_sel == 3'b011) || (mem_sel == 3'b110) || (mem_sel == 3'b111)) mem_rdata = mem_raw;
    else mem_rdata = ext(mem_sel, mem_raw);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: memory write mid-cycle, then observe the new cycle's outputs.
  task automatic tick();
    @(negedge clk);
    if (rst_n && mem_write)
      for (int i = 0; i < nbytes(mem_sel); i++) mem[mem_addr + 12'(i)] = mem_wdata[8*i +: 8];
    @(posedge clk);
    #1;
    cyc++;
    chk("rw_exclusive", 32'(mem_write & mem_read), 32'd0);
    if (mem_write) begin
      wr_log.push_back('{mem_addr, mem_sel, mem_wdata});
      writes_seen++;
    end
    if (ld_valid) ld_log.push_back('{cyc, ld_data});
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] sel,
                       input logic [11:0] addr, input logic [31:0] data);
    req_valid = v; req_we = we; req_sel = sel; req_addr = addr; req_wdata = data;
    #2;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 3'b000, 12'd0, 32'd0);
    repeat (n) tick();
  endtask

  task automatic do_store(input logic [2:0] sel, input logic [11:0] addr,
                          input logic [31:0] data, input string tag);
    drive(1'b1, 1'b1, sel, addr, data);
    chk({tag, "_st_ready"}, 32'(req_ready), 32'd1);
    tick();
  endtask

  task automatic do_load(input logic [2:0] sel, input logic [11:0] addr,
                         input logic [31:0] exp, input string tag, output int waits);
    int acc;
    waits = 0;
    drive(1'b1, 1'b0, sel, addr, 32'd0);
    while (!req_ready && waits < 20) begin
      tick();
      waits++;
      drive(1'b1, 1'b0, sel, addr, 32'd0);
    end
    if (!req_ready) begin
      chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
      drive(1'b0, 1'b0, 3'b000, 12'd0, 32'd0);
      return;
    end
    acc = cyc;
    tick();
    drive(1'b0, 1'b0, 3'b000, 12'd0, 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd1);
    tick();
    chk({tag, "_ld_valid"}, 32'(ld_valid), 32'd1);
    chk({tag, "_ld_data"}, ld_data, exp);
    $display("load %s sel=%0d addr=0x%03h accepted@%0d waits=%0d data=0x%08h", tag, sel, addr, acc, waits, ld_data);
    tick();
    chk({tag, "_ld_pulse"}, 32'(ld_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ld_valid"},  32'(ld_valid), 32'd0);
    chk({tag, "_ld_data"},   ld_data, 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_mem_read"},  32'(mem_read), 32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_mem_sel"},   32'(mem_sel), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_sb_count"},  32'(sb_count), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_sb_empty"},  32'(sb_empty), 32'd1);
  endtask

  // Random-phase scoreboards
  wr_t exp_wr[$];
  ld_t exp_ld[$];

  task automatic proc_logs();
    while (wr_log.size() > 0) begin
      wr_t g, e;
      g = wr_log.pop_front();
      if (exp_wr.size() == 0) begin
        chk("rnd_unexpected_write", 32'(g.a), 32'hFFFF_FFFF);
      end else begin
        e = exp_wr.pop_front();
        chk("rnd_wr_addr", 32'(g.a), 32'(e.a));
        chk("rnd_wr_sel", 32'(g.s), 32'(e.s));
        chk("rnd_wr_data", g.d, e.d);
      end
    end
    while (ld_log.size() > 0) begin
      ld_t g, e;
      g = ld_log.pop_front();
      if (exp_ld.size() == 0) begin
        chk("rnd_unexpected_ld", g.d, 32'hFFFF_FFFF);
      end else begin
        e = exp_ld.pop_front();
        chk("rnd_ld_cycle", 32'(g.c), 32'(e.c));
        chk("rnd_ld_data", g.d, e.d);
        $display("rnd load done cycle=%0d data=0x%08h", g.c, g.d);
      end
    end
  endtask

  vec_t vt [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, ws, pushed, base_w, last_ld_acc, cnt;
    logic [31:0] d10 [10];

    vt[0] = '{3'b010, 12'h010, 32'hDEADBEEF, 3'b010, 12'h010, 32'hDEADBEEF};
    vt[1] = '{3'b000, 12'h030, 32'h00000080, 3'b000, 12'h030, 32'hFFFFFF80};
    vt[2] = '{3'b000, 12'h030, 32'h00000080, 3'b100, 12'h030, 32'h00000080};
    vt[3] = '{3'b001, 12'h040, 32'hABCD8001, 3'b001, 12'h040, 32'hFFFF8001};
    vt[4] = '{3'b001, 12'h040, 32'hABCD8001, 3'b101, 12'h040, 32'h00008001};
    vt[5] = '{3'b000, 12'h050, 32'h1234567F, 3'b000, 12'h050, 32'h0000007F};
    vt[6] = '{3'b010, 12'h060, 32'h12345678, 3'b111, 12'h060, 32'h00000000};
    vt[7] = '{3'b010, 12'h064, 32'hCAFEF00D, 3'b000, 12'h067, 32'hFFFFFFCA};
    vt[8] = '{3'b010, 12'h068, 32'h55AA55AA, 3'b011, 12'h068, 32'h00000000};

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

    // Power-on reset with a load presented: nothing may leak through.
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_sel = 3'b010; req_addr = 12'h123; req_wdata = 32'h0;
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Reset in the middle of traffic: ld_data and the port carry live values first.
    do_store(3'b010, 12'h080, 32'h11223344, "rst");
    do_load(3'b010, 12'h080, 32'h11223344, "rst_pre", w);
    do_store(3'b010, 12'h090, 32'hAAAA5555, "rst");
    do_store(3'b010, 12'h094, 32'h5555AAAA, "rst");
    drive(1'b1, 1'b1, 3'b010, 12'h098, 32'h0F0F0F0F);
    chk("rst_mid_write_active", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    tick();
    check_reset_outputs("rst_held");
    drive(1'b0, 1'b0, 3'b000, 12'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ws = writes_seen;
    idle(6);
    chk("rst_no_write_after", 32'(writes_seen - ws), 32'd0);
    chk("rst_count_after", 32'(sb_count), 32'd0);
    $display("reset sequence done at cycle %0d", cyc);

    // Directed store-then-load vectors; each load must stall exactly one cycle.
    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      idle(2);
      wr_log.delete();
      do_store(vt[i].st_sel, vt[i].st_addr, vt[i].st_data, tag);
      do_load(vt[i].ld_sel, vt[i].ld_addr, vt[i].exp, tag, w);
      chk({tag, "_stall"}, 32'(w), 32'd1);
      chk({tag, "_nwrites"}, 32'(wr_log.size()), 32'd1);
      if (wr_log.size() == 1) begin
        chk({tag, "_wr_addr"}, 32'(wr_log[0].a), 32'(vt[i].st_addr));
        chk({tag, "_wr_sel"}, 32'(wr_log[0].s), 32'(vt[i].st_sel));
        chk({tag, "_wr_data"}, wr_log[0].d, vt[i].st_data);
      end
    end

    // Back-to-back byte stores: each pushes while the previous drains.
    idle(2);
    wr_log.delete();
    for (int i = 0; i < 4; i++) begin
      do_store(3'b000, 12'h020 + 12'(i), 32'hA0 + 32'(i), "b2b");
      chk("b2b_count", 32'(sb_count), 32'd1);
    end
    idle(3);
    chk("b2b_empty", 32'(sb_empty), 32'd1);
    chk("b2b_nwrites", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      chk("b2b_wr_addr", 32'(wr_log[i].a), 32'h20 + 32'(i));
      chk("b2b_wr_data", wr_log[i].d, 32'hA0 + 32'(i));
    end
    $display("b2b stores: %0d writes observed", wr_log.size());

    // Ten word stores run the pointers around the ring more than once.
    idle(2);
    wr_log.delete();
    for (int i = 0; i < 10; i++) begin
      d10[i] = $urandom;
      do_store(3'b010, 12'h200 + 12'(4*i), d10[i], "wrap");
    end
    idle(3);
    chk("wrap_nwrites", 32'(wr_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
      chk("wrap_wr_addr", 32'(wr_log[i].a), 32'h200 + 32'(4*i));
      chk("wrap_wr_data", wr_log[i].d, d10[i]);
    end
    do_load(3'b010, 12'h200, d10[0], "wrap_first", w);
    chk("wrap_no_stall", 32'(w), 32'd0);
    do_load(3'b010, 12'h224, d10[9], "wrap_last", w);

    // Stores with non-B/H/W sel are accepted and dropped.
    idle(2);
    for (int s = 3; s < 8; s++) begin
      ws = writes_seen;
      do_store(3'(s), 12'h070, 32'h0000FFFF, "bad_sel");
      chk("bad_sel_count", 32'(sb_count), 32'd0);
      idle(3);
      chk("bad_sel_no_write", 32'(writes_seen - ws), 32'd0);
      $display("store sel=%0d dropped", s);
    end

    // Randomized traffic against the golden memory.
    idle(3);
    for (int i = 0; i < 4096; i++) gmem[i] = mem[i];
    wr_log.delete(); ld_log.delete(); exp_wr.delete(); exp_ld.delete();
    pushed = 0;
    base_w = writes_seen;
    last_ld_acc = -10;
    for (int n = 0; n < 600; n++) begin
      logic v, we;
      logic [2:0] sel;
      logic [11:0] addr;
      logic [31:0] data;
      v    = ($urandom_range(0, 99) < 70);
      we   = 1'($urandom_range(0, 1));
      sel  = 3'($urandom_range(0, 7));
      if (we && $urandom_range(0, 3) != 0) sel = 3'($urandom_range(0, 2));
      addr = 12'h100 + 12'($urandom_range(0, 31));
      data = $urandom;
      drive(v, we, sel, addr, data);
      cnt = pushed - (writes_seen - base_w);
      if (we) chk("rnd_st_ready", 32'(req_ready), 32'(cnt < 4));
      else    chk("rnd_ld_ready", 32'(req_ready), 32'((cnt == 0) && (cyc != last_ld_acc + 1)));
      if (v && req_ready) begin
        if (we) begin
          if (sel == 3'b000 || sel == 3'b001 || sel == 3'b010) begin
            for (int b = 0; b < nbytes(sel); b++) gmem[addr + 12'(b)] = data[8*b +: 8];
            exp_wr.push_back('{addr, sel, data});
            pushed++;
          end
        end else begin
          exp_ld.push_back('{cyc + 2, ext(sel, graw(addr))});
          last_ld_acc = cyc;
        end
      end
      tick();
      proc_logs();
      chk("rnd_sb_count", 32'(sb_count), 32'(pushed - (writes_seen - base_w)));
      chk("rnd_sb_empty", 32'(sb_empty), 32'(sb_count == 3'd0));
    end
    idle(6);
    proc_logs();
    chk("rnd_writes_left", 32'(exp_wr.size()), 32'd0);
    chk("rnd_loads_left", 32'(exp_ld.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
